sparc_ifu_fetch_sched: RTL and testbench

- Burst-aware round-robin scheduler that shares the single IFU fetch/fill resource among four threads.
- Each grant is held for a multi-beat burst. The grant is released on the last acknowledged beat or on request withdrawal.
- A rotating one-hot park pointer gives least priority to the last-served thread.
- Sits between the thread-select logic (requesters) and the fetch datapath (ack source).

---
 rtl/sparc_ifu_fetch_sched.sv | 158 +++++++++++++++
 tb/tb_sparc_ifu_fetch_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_fetch_sched.sv
// Burst-aware round-robin scheduler sharing the IFU fetch/fill resource among four threads.
// Optional starvation escalation is enabled by defining SPARC_IFU_FSCHED_STARVE_EN.
module sparc_ifu_fetch_sched #(
    parameter int LEN_W      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               arst_l,
    input  logic [3:0]         req_vec,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic               ack,
    input  logic               halt,
    output logic [3:0]         grant_vec,
    output logic               grant_vld,
    output logic               last_beat,
    output logic [3:0]         park_vec
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must fit a 4-bit saturating wait counter");
    end

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_grant, w_grant_nxt;
    logic [3:0]       r_park, w_park_nxt;
    logic [LEN_W-1:0] r_beat, w_beat_nxt;

    logic [3:0]       w_cand;
    logic [3:0]       w_arb_park;
    logic [3:0]       w_pick;
    logic [LEN_W-1:0] w_pick_len;
    logic             w_own_req;
    logic             w_done;

    function automatic logic [1:0] f_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

    // Offsets scanned from farthest to nearest so the thread right after park wins.
    function automatic logic [3:0] f_rr_pick(input logic [3:0] req, input logic [3:0] park);
        logic [1:0] base;
        logic [1:0] t;
        logic [3:0] pick;
        base = f_idx(park);
        pick = 4'b0000;
        for (int k = 4; k >= 1; k--) begin
            t = base + 2'(k);
            if (req[t]) pick = 4'b0001 << t;
        end
        return pick;
    endfunction

`ifdef SPARC_IFU_FSCHED_STARVE_EN
    localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

    logic [3:0] r_wait [4];
    logic [3:0] w_starved;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int k = 0; k < 4; k++) r_wait[k] <= 4'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!req_vec[k] || r_grant[k]) r_wait[k] <= 4'd0;
                else if (r_wait[k] != 4'hF)    r_wait[k] <= r_wait[k] + 4'd1;
            end
        end
    end

    always_comb begin
        w_starved = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_starved[k] = req_vec[k] && (r_wait[k] >= STARVE_TH);
        end
    end

    assign w_cand = (|w_starved) ? w_starved : req_vec;
`else
    assign w_cand = req_vec;
`endif

    // In BUSY, arbitration only matters at release, when the current grant becomes the park.
    assign w_arb_park = (r_state == ST_BUSY) ? r_grant : r_park;
    assign w_pick     = f_rr_pick(w_cand, w_arb_park);

    always_comb begin
        w_pick_len = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_pick[k]) w_pick_len = req_len[k*LEN_W +: LEN_W];
        end
    end

    assign w_own_req = |(req_vec & r_grant);
    assign w_done    = (r_state == ST_BUSY) && (!w_own_req || (ack && (r_beat == '0)));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_park_nxt  = r_park;
        w_beat_nxt  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (!halt && (|req_vec)) begin
                    w_grant_nxt = w_pick;
                    w_beat_nxt  = w_pick_len;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_park_nxt = r_grant;
                    if (!halt && (|req_vec)) begin
                        w_grant_nxt = w_pick;
                        w_beat_nxt  = w_pick_len;
                    end else begin
                        w_grant_nxt = 4'b0000;
                        w_beat_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (ack) begin
                    w_beat_nxt = r_beat - LEN_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_park  <= 4'b0001;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_park  <= w_park_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign grant_vec = r_grant;
    assign grant_vld = |r_grant;
    assign last_beat = (|r_grant) && (r_beat == '0);
    assign park_vec  = r_park;

endmodule

// File: tb/tb_sparc_ifu_fetch_sched.sv
// Bench for sparc_ifu_fetch_sched: directed scenarios plus a per-cycle behavioural model check.
module tb_sparc_ifu_fetch_sched;

    localparam int LEN_W = 2;

    logic             clk = 1'b0;
    logic             arst_l = 1'b0;
    logic [3:0]       req_vec = 4'b0000;
    logic [4*LEN_W-1:0] req_len = '0;
    logic             ack = 1'b0;
    logic             halt = 1'b0;
    logic [3:0]       grant_vec;
    logic             grant_vld;
    logic             last_beat;
    logic [3:0]       park_vec;

    int total = 0;
    int bad = 0;

    sparc_ifu_fetch_sched #(.LEN_W(LEN_W), .STARVE_MAX(8)) dut (
        .clk       (clk),
        .arst_l    (arst_l),
        .req_vec   (req_vec),
        .req_len   (req_len),
        .ack       (ack),
        .halt      (halt),
        .grant_vec (grant_vec),
        .grant_vld (grant_vld),
        .last_beat (last_beat),
        .park_vec  (park_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Model: owner thread (-1 idle), beats left after the current one, last-served thread.
    int m_owner = -1;
    int m_left  = 0;
    int m_last  = 0;
    int m_req, m_pick;
    bit m_done;

    function automatic int rr_pick(input int req, input int last);
        for (int d = 1; d <= 4; d++) begin
            int t;
            t = (last + d) % 4;
            if (((req >> t) & 1) != 0) return t;
        end
        return -1;
    endfunction

    function automatic int len_of(input int t);
        return int'((req_len >> (LEN_W * t)) & 8'h03);
    endfunction

    always @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            m_owner = -1;
            m_left  = 0;
            m_last  = 0;
        end else begin
            m_req = int'(req_vec);
            if (m_owner < 0) begin
                if (!halt && m_req != 0) begin
                    m_owner = rr_pick(m_req, m_last);
                    m_left  = len_of(m_owner);
                end
            end else begin
                m_done = (((m_req >> m_owner) & 1) == 0) || (ack && m_left == 0);
                if (m_done) begin
                    m_last = m_owner;
                    if (!halt && m_req != 0) begin
                        m_pick  = rr_pick(m_req, m_last);
                        m_owner = m_pick;
                        m_left  = len_of(m_pick);
                    end else begin
                        m_owner = -1;
                        m_left  = 0;
                    end
                end else if (ack) begin
                    m_left = m_left - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e_grant;
        e_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("model_grant_vec", {4'h0, grant_vec}, {4'h0, e_grant});
        chk("model_grant_vld", {7'h0, grant_vld}, {7'h0, (m_owner >= 0)});
        chk("model_last_beat", {7'h0, last_beat}, {7'h0, (m_owner >= 0 && m_left == 0)});
        chk("model_park_vec", {4'h0, park_vec}, {4'h0, 4'b0001 << m_last});
    end

    task automatic do_reset();
        @(negedge clk);
        req_vec = 4'b0000;
        req_len = '0;
        ack     = 1'b0;
        halt    = 1'b0;
        arst_l  = 1'b0;
        @(negedge clk);
        arst_l  = 1'b1;
    endtask

    logic [3:0] s1_seq [5];

    initial begin
        s1_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset state, then all four requesting with single-beat bursts.
        do_reset();
        chk("rst_grant", {4'h0, grant_vec}, 8'h00);
        chk("rst_vld", {7'h0, grant_vld}, 8'h00);
        chk("rst_last", {7'h0, last_beat}, 8'h00);
        chk("rst_park", {4'h0, park_vec}, 8'h01);
        req_vec = 4'b1111;
        ack     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_order", {4'h0, grant_vec}, {4'h0, s1_seq[i]});
        end

        // Thread 2, four beats, acked every other cycle.
        do_reset();
        req_vec = 4'b0100;
        req_len = 8'h30;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("burst_hold", {4'h0, grant_vec}, 8'h04);
            chk("burst_last", {7'h0, last_beat}, {7'h0, (k >= 7)});
            if (k == 8) begin
                ack     = 1'b1;
                req_vec = 4'b0000;
            end else begin
                ack = (k % 2 == 0);
            end
        end
        @(negedge clk);
        chk("burst_end_grant", {4'h0, grant_vec}, 8'h00);
        chk("burst_end_park", {4'h0, park_vec}, 8'h04);
        ack = 1'b0;

        // Thread 1 withdraws mid-burst while thread 3 waits.
        do_reset();
        req_vec = 4'b0010;
        req_len = 8'h08;
        @(negedge clk);
        chk("wd_grant1", {4'h0, grant_vec}, 8'h02);
        ack     = 1'b1;
        req_vec = 4'b1010;
        @(negedge clk);
        chk("wd_hold", {4'h0, grant_vec}, 8'h02);
        chk("wd_last", {7'h0, last_beat}, 8'h00);
        req_vec = 4'b1000;
        ack     = 1'b0;
        @(negedge clk);
        chk("wd_grant3", {4'h0, grant_vec}, 8'h08);
        chk("wd_park", {4'h0, park_vec}, 8'h02);
        req_vec = 4'b0000;

        // halt during thread 0's two-beat burst.
        do_reset();
        req_vec = 4'b0001;
        req_len = 8'h01;
        @(negedge clk);
        chk("halt_grant0", {4'h0, grant_vec}, 8'h01);
        halt    = 1'b1;
        req_vec = 4'b0101;
        ack     = 1'b1;
        @(negedge clk);
        chk("halt_beat2", {4'h0, grant_vec}, 8'h01);
        chk("halt_last", {7'h0, last_beat}, 8'h01);
        @(negedge clk);
        chk("halt_idle", {4'h0, grant_vec}, 8'h00);
        chk("halt_park", {4'h0, park_vec}, 8'h01);
        ack     = 1'b0;
        req_vec = 4'b0100;
        @(negedge clk);
        chk("halt_still_idle", {4'h0, grant_vec}, 8'h00);
        halt = 1'b0;
        @(negedge clk);
        chk("halt_release", {4'h0, grant_vec}, 8'h04);
        req_vec = 4'b0000;

        // Async reset in the middle of a burst, with ack held high.
        do_reset();
        req_vec = 4'b0010;
        req_len = 8'h0C;
        @(negedge clk);
        chk("ar_grant", {4'h0, grant_vec}, 8'h02);
        ack = 1'b1;
        @(negedge clk);
        chk("ar_mid", {4'h0, grant_vec}, 8'h02);
        #2 arst_l = 1'b0;
        #1;
        chk("ar_now_grant", {4'h0, grant_vec}, 8'h00);
        chk("ar_now_park", {4'h0, park_vec}, 8'h01);
        chk("ar_now_vld", {7'h0, grant_vld}, 8'h00);
        @(negedge clk);
        chk("ar_held", {4'h0, grant_vec}, 8'h00);
        req_vec = 4'b0000;
        arst_l  = 1'b1;
        @(negedge clk);
        chk("ar_after", {4'h0, grant_vec}, 8'h00);
        chk("ar_after_last", {7'h0, last_beat}, 8'h00);
        ack = 1'b0;

        // Mixed traffic checked cycle by cycle against the model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_vec = 4'($urandom_range(0, 15));
            req_len = 8'($urandom_range(0, 255));
            ack     = ($urandom_range(0, 2) != 0);
            halt    = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
